// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module     : register_file_mp
// Description: Multi-read-port register file with clear sequencer, optional
//              write-to-read bypass and a registered debug read port.
// Revision   : 1.0
// ============================================================================
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_sel_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     clear_i,
  output logic                     busy_o,
  input  logic [ADDR_W-1:0]        dbg_sel_i,
  output logic [DATA_W-1:0]        dbg_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          cnt;
  logic                       busy;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]          dbg_data;
  logic [DATA_W-1:0]          mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0]   rd_next;
  logic [DATA_W-1:0]          dbg_next;
  logic                       wr_go;

  assign wr_go = (state == READY) && wr_en_i && !clear_i &&
                 !((ZERO_REG != 0) && (wr_sel_i == '0));

  // Zero-register hit takes priority over the bypass path.
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] sel;
      logic              zero_hit;
      logic              fwd_hit;
      assign sel      = rd_sel_i[k*ADDR_W +: ADDR_W];
      assign zero_hit = (ZERO_REG != 0) && (sel == '0);
      assign fwd_hit  = (BYPASS != 0) && wr_en_i && (wr_sel_i == sel);
      assign rd_next[k*DATA_W +: DATA_W] = zero_hit ? '0 :
                                           fwd_hit  ? wr_data_i : mem[sel];
    end
  endgenerate

  assign dbg_next = ((ZERO_REG != 0) && (dbg_sel_i == '0)) ? '0 : mem[dbg_sel_i];

  // Storage is deliberately not reset; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_go) begin
      mem[wr_sel_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= CLEAR;
      cnt      <= '0;
      busy     <= 1'b1;
      rd_data  <= '0;
      dbg_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rd_data  <= '0;
          dbg_data <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (clear_i) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            rd_data  <= '0;
            dbg_data <= '0;
          end else begin
            for (int k = 0; k < NUM_RD; k++) begin
              if (rd_en_i[k]) begin
                rd_data[k*DATA_W +: DATA_W] <= rd_next[k*DATA_W +: DATA_W];
              end
            end
            dbg_data <= dbg_next;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign rd_data_o  = rd_data;
  assign busy_o     = busy;
  assign dbg_data_o = dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module     : tb_register_file_mp
// Description: Scoreboard bench for register_file_mp; instance a uses
//              ZERO_REG=1/BYPASS=1, instance b uses ZERO_REG=0/BYPASS=0.
// Revision   : 1.0
// ============================================================================
module tb_register_file_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int RW     = NUM_RD * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n_i;
  logic                     wr_en;
  logic                     clear;
  logic [ADDR_W-1:0]        wr_sel;
  logic [ADDR_W-1:0]        dbg_sel;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_sel;
  logic [RW-1:0]            rd_o   [2];
  logic                     busy_o [2];
  logic [DATA_W-1:0]        dbg_o  [2];

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                     .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n_i(rst_n_i), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
    .rd_data_o(rd_o[0]), .clear_i(clear), .busy_o(busy_o[0]),
    .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_o[0]));

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                     .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n_i(rst_n_i), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_sel_i(rd_sel),
    .rd_data_o(rd_o[1]), .clear_i(clear), .busy_o(busy_o[1]),
    .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_o[1]));

  // Reference model: contents per instance plus the number of clear cycles left.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  int                m_left;
  logic [RW-1:0]     m_rd  [2];
  logic [DATA_W-1:0] m_dbg [2];

  typedef struct packed {
    logic [1:0]             busy;
    logic [1:0][RW-1:0]     rd;
    logic [1:0][DATA_W-1:0] dbg;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit zr(int d);
    return d == 0;
  endfunction

  function automatic bit bp(int d);
    return d == 0;
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    for (int d = 0; d < 2; d++) begin
      m_rd[d]  = '0;
      m_dbg[d] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n_i) begin
      model_reset();
    end else if (m_left > 0) begin
      for (int d = 0; d < 2; d++) begin
        m_mem[d][DEPTH - m_left] = '0;
        m_rd[d]  = '0;
        m_dbg[d] = '0;
      end
      m_left--;
    end else if (clear) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NUM_RD; k++) begin
          if (rd_en[k]) begin
            int a;
            logic [DATA_W-1:0] v;
            a = int'(rd_sel[k*ADDR_W +: ADDR_W]);
            if (zr(d) && a == 0) v = '0;
            else if (bp(d) && wr_en && int'(wr_sel) == a) v = wr_data;
            else v = m_mem[d][a];
            m_rd[d][k*DATA_W +: DATA_W] = v;
          end
        end
        m_dbg[d] = (zr(d) && dbg_sel == '0) ? '0 : m_mem[d][dbg_sel];
        if (wr_en && !(zr(d) && wr_sel == '0)) m_mem[d][wr_sel] = wr_data;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    for (int d = 0; d < 2; d++) begin
      e.busy[d] = (m_left > 0);
      e.rd[d]   = m_rd[d];
      e.dbg[d]  = m_dbg[d];
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    clear = 1'b0;
    rd_en = '0;
  endtask

  function automatic logic [ADDR_W-1:0] addr_rand();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  task automatic rand_reads();
    rd_en = NUM_RD'($urandom);
    for (int k = 0; k < NUM_RD; k++) rd_sel[k*ADDR_W +: ADDR_W] = addr_rand();
    dbg_sel = addr_rand();
  endtask

  task automatic read_all();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = '1;
      for (int k = 0; k < NUM_RD; k++) rd_sel[k*ADDR_W +: ADDR_W] = ADDR_W'((i + k) % DEPTH);
      dbg_sel = ADDR_W'(i);
      step();
    end
    idle();
    step();
  endtask

  task automatic write(input int a, input logic [DATA_W-1:0] v);
    idle();
    wr_en   = 1'b1;
    wr_sel  = ADDR_W'(a);
    wr_data = v;
    step();
    idle();
  endtask

  // Monitor: every cycle the DUTs present registered outputs; compare with queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int d = 0; d < 2; d++) begin
          check($sformatf("busy[%0d]", d), RW'(busy_o[d]), RW'(e.busy[d]));
          check($sformatf("rd_data[%0d]", d), rd_o[d], e.rd[d]);
          check($sformatf("dbg_data[%0d]", d), RW'(dbg_o[d]), RW'(e.dbg[d]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i = 1'b0;
    idle();
    wr_sel  = '0;
    wr_data = '0;
    rd_sel  = '0;
    dbg_sel = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
    model_reset();
    @(negedge clk);
    repeat (3) step();

    // Release reset; reads toggled during the initial clear must stay 0.
    rst_n_i = 1'b1;
    repeat (DEPTH + 2) begin
      rand_reads();
      step();
    end
    read_all();

    // Basic write then read.
    write(5, 32'hDEADBEEF);
    rd_en = 2'b01;
    rd_sel[0 +: ADDR_W] = 5'd5;
    step();
    idle();
    step();

    // Same-cycle write and read on port 1.
    write(7, 32'hDEADBEEF);
    wr_en   = 1'b1;
    wr_sel  = 5'd7;
    wr_data = 32'h12345678;
    rd_en   = 2'b10;
    rd_sel[ADDR_W +: ADDR_W] = 5'd7;
    step();
    idle();
    rd_en = 2'b10;
    step();
    idle();
    step();

    // Entry 0 behaviour.
    write(0, 32'hFFFFFFFF);
    rd_en   = 2'b11;
    rd_sel  = '0;
    dbg_sel = '0;
    step();
    idle();
    step();

    // Randomized traffic with occasional clear requests.
    repeat (400) begin
      wr_en   = $urandom_range(0, 1) == 1;
      wr_sel  = addr_rand();
      wr_data = $urandom;
      clear   = ($urandom_range(0, 63) == 0);
      rand_reads();
      step();
    end
    idle();
    while (m_left > 0) step();

    // Fill, then clear together with a write.
    for (int i = 1; i < DEPTH; i++) write(i, DATA_W'(i));
    wr_en   = 1'b1;
    wr_sel  = 5'd3;
    wr_data = 32'hAAAA5555;
    clear   = 1'b1;
    step();
    idle();
    repeat (DEPTH + 2) begin
      rand_reads();
      step();
    end
    read_all();

    // Reset asserted mid-clear.
    for (int i = 1; i < 8; i++) write(i, $urandom);
    rd_en = '1;
    step();
    idle();
    clear = 1'b1;
    step();
    idle();
    repeat (10) begin
      rand_reads();
      step();
    end
    rst_n_i = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("async busy[%0d]", d), RW'(busy_o[d]), RW'(1'b1));
      check($sformatf("async rd_data[%0d]", d), rd_o[d], '0);
      check($sformatf("async dbg_data[%0d]", d), RW'(dbg_o[d]), '0);
    end
    model_reset();
    @(negedge clk);
    repeat (2) step();
    rst_n_i = 1'b1;
    repeat (DEPTH + 2) begin
      rand_reads();
      step();
    end
    read_all();

    idle();
    repeat (3) step();
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port register file for the CPU core; next generation of the single-write/dual-read register file.
- Adds configurable width, depth and read-port count, per-port read enables, and optional write-to-read bypass.
- Adds a hardware clear sequencer (after reset or on request) and a registered debug read port, which replaces the per-register debug outputs.
- Sits between decode (read) and writeback (write).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero (writes dropped, reads return 0)
- BYPASS, 1, 1 = same-cycle write to the addressed entry is forwarded to the read output

Ports:
- clk  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- wr_en_i  in  1  write enable
- wr_sel_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- rd_en_i  in  NUM_RD  per-port read enable
- rd_sel_i  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]
- clear_i  in  1  request to zero all entries (single-cycle pulse)
- busy_o  out  1  clear sequence in progress
- dbg_sel_i  in  ADDR_W  debug read address
- dbg_data_o  out  DATA_W  registered debug read data

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n_i.
- Reset values while rst_n_i = 0: all rd_data_o = 0, dbg_data_o = 0, busy_o = 1, FSM = CLEAR, clear counter = 0. The storage array is not reset asynchronously; the sequencer zeroes it.
- FSM states:
  - CLEAR: each cycle write 0 to entry[cnt], then cnt++.
  - When cnt = DEPTH-1 has been written, go to READY on the next edge.
  - The clear therefore takes exactly DEPTH cycles after rst_n_i deasserts.
  - busy_o is high throughout CLEAR and low in READY (registered, so no glitches).
  - READY: normal operation. clear_i = 1 returns to CLEAR with cnt = 0 and busy_o = 1 from the next cycle.
- During CLEAR:
  - wr_en_i is ignored.
  - rd_data_o and dbg_data_o hold 0.
  - clear_i is ignored; the sequence is not restarted.
- Reset mid-clear: the sequence restarts at cnt = 0.
- Write (READY only): at the clk edge with wr_en_i = 1, entry[wr_sel_i] <= wr_data_i. With ZERO_REG = 1 and wr_sel_i = 0, the write is dropped.
- Read latency is one cycle:
  - If rd_en_i[k] = 1 at edge N, rd_data_o[k] shows entry[rd_sel_k] from edge N on.
  - If rd_en_i[k] = 0, rd_data_o[k] holds its previous value.
- Read/write same cycle, same address, BYPASS = 1: rd_data_o[k] = wr_data_i (new value).
- Read/write same cycle, same address, BYPASS = 0: rd_data_o[k] = old entry contents.
- Reads of address 0 with ZERO_REG = 1 always return 0, including under bypass.
- Multiple read ports may address the same entry; each returns identical data.
- Debug port: dbg_data_o <= entry[dbg_sel_i] every READY cycle, with one-cycle latency. It never bypasses.
- clear_i and wr_en_i asserted together in READY: the clear wins and the write is dropped.
- Widths: no arithmetic. Addresses use the full ADDR_W range, so there is no out-of-range case.

Test Plan:
- Reset, then release rst_n_i with DEPTH = 32 → busy_o high for exactly 32 cycles, then low. Reading all 32 entries returns 0x00000000.
- Write 0xDEADBEEF to entry 5, then read port 0 at addr 5 next cycle → rd_data_o[0] = 0xDEADBEEF one cycle after rd_en_i.
- Same-cycle write of 0x12345678 to entry 7 with port 1 reading addr 7:
  - BYPASS = 1 → 0x12345678.
  - BYPASS = 0 → prior value 0xDEADBEEF, and 0x12345678 on the following read.
- ZERO_REG = 1: write 0xFFFFFFFF to entry 0 → reads and debug port return 0. With ZERO_REG = 0 → 0xFFFFFFFF.
- Fill entries 1..31 with their index, pulse clear_i together with wr_en_i (entry 3 = 0xAAAA5555) → write dropped, busy_o high 32 cycles, all entries 0. rd_en_i toggled during the clear → rd_data_o stays 0.
- Assert rst_n_i low at clear cycle 10 for 2 cycles → outputs 0 immediately (asynchronous). After release, busy_o is high a full 32 cycles again.
